sdram_weight_fetcher: RTL

Fetches one 256-bit weight line (16 x 16-bit words) from the SDRAM controller's 16-bit read port whenever the Accelerator asserts sdram_rd_req. It presents the assembled line on rd_buf and signals completion with rd_done. It sits between the SDRAM controller and the Accelerator's SDRAM_FIFO_in/DVAL inputs, replacing fakeSDRAM. Reads are pipelined, and the line address auto-advances so consecutive requests stream the weight matrix.

---
 rtl/sdram_fetch_pkg.sv | 17 +
 rtl/fetch_line_assembler.sv | 32 +++
 rtl/sdram_weight_fetcher.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sdram_fetch_pkg.sv
// Shared types for the SDRAM weight-line fetcher.
// FSM state encoding, line geometry and the 256-bit line type.
package sdram_fetch_pkg;

    localparam int WORDS_PER_LINE = 16;
    localparam int WORD_W         = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

endpackage

// File: rtl/fetch_line_assembler.sv
// Collects returned SDRAM words into a line, in return order.
// Ports: clr restarts the word count; wr_en/wr_data write the next word;
// line is the assembly register; line_full is high once 16 words landed.
module fetch_line_assembler
    import sdram_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output line_t             line,
    output logic              line_full
);

    logic [4:0] ret_cnt;

    assign line_full = ret_cnt[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line    <= '0;
            ret_cnt <= '0;
        end else if (clr) begin
            ret_cnt <= '0;
        end else if (wr_en && !line_full) begin
            line[ret_cnt[3:0]] <= wr_data;
            ret_cnt            <= ret_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/sdram_weight_fetcher.sv
// Fetches one 16-word weight line per request from a pipelined SDRAM port.
// Ports: base_addr/addr_load set the line address, sdram_rd_req starts a
// fetch, rd_buf/rd_done deliver the line, busy flags activity; sdram_*
// is the controller read interface (address/read/waitrequest/data/valid).
module sdram_weight_fetcher
    import sdram_fetch_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int WORDS     = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_OUTST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              addr_load,
    input  logic              sdram_rd_req,
    output line_t             rd_buf,
    output logic              rd_done,
    output logic              busy,
    output logic [ADDR_W-1:0] sdram_address,
    output logic              sdram_read,
    input  logic              sdram_waitrequest,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_readdatavalid
);

    state_t            state;
    logic [4:0]        issue_cnt;
    logic [3:0]        outstanding;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] shadow_addr;
    logic              shadow_vld;
    logic              pending;
    logic              accept;
    logic              start;
    logic              rdv_live;
    line_t             asm_line;
    logic              line_full;

    assign sdram_read = (state == ISSUE) && !issue_cnt[4]
                        && (outstanding < 4'(MAX_OUTST));
    assign sdram_address = line_addr + ADDR_W'(issue_cnt);
    assign accept   = sdram_read && !sdram_waitrequest;
    assign start    = (state == IDLE) && (sdram_rd_req || pending);
    // Returns seen in IDLE are leftovers from an aborted fetch.
    assign rdv_live = sdram_readdatavalid
                      && ((state == ISSUE) || (state == DRAIN));
    assign busy     = (state != IDLE) || pending;

    fetch_line_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start),
        .wr_en     (rdv_live),
        .wr_data   (sdram_readdata),
        .line      (asm_line),
        .line_full (line_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            outstanding <= '0;
            line_addr   <= '0;
            shadow_addr <= '0;
            shadow_vld  <= 1'b0;
            pending     <= 1'b0;
            rd_buf      <= '0;
            rd_done     <= 1'b0;
        end else begin
            rd_done <= 1'b0;

            if (accept && !sdram_readdatavalid)
                outstanding <= outstanding + 4'd1;
            else if (!accept && sdram_readdatavalid && outstanding != 4'd0)
                outstanding <= outstanding - 4'd1;

            if (state != IDLE && sdram_rd_req)
                pending <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (addr_load)
                        line_addr <= base_addr;
                    if (start) begin
                        pending   <= 1'b0;
                        issue_cnt <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (addr_load) begin
                        shadow_addr <= base_addr;
                        shadow_vld  <= 1'b1;
                    end
                    if (accept) begin
                        issue_cnt <= issue_cnt + 5'd1;
                        if (issue_cnt == 5'(WORDS - 1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (addr_load) begin
                        shadow_addr <= base_addr;
                        shadow_vld  <= 1'b1;
                    end
                    if (line_full) begin
                        rd_buf  <= asm_line;
                        rd_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // A reload wins over the auto-advance to the next line.
                    if (addr_load)
                        line_addr <= base_addr;
                    else if (shadow_vld)
                        line_addr <= shadow_addr;
                    else
                        line_addr <= line_addr + ADDR_W'(WORDS);
                    shadow_vld <= 1'b0;
                    issue_cnt  <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
